// File: rtl/montgomery_digit_serial.sv
// Digit-serial Montgomery multiplier, result = x*y*2^(-DIGIT_W*n) mod m. Optional operand check: MONT_OPERAND_CHECK_EN.
// Latency n+2 cycles from accept to valid_o. start_i is ignored while busy_o=1 and can be accepted again in the valid_o cycle.
module montgomery_digit_serial #(
    parameter int DATA_LENGTH = 64,
    parameter int DIGIT_W     = 4
) (
    input  logic                   CLK_pci_sys_clk_p,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [DATA_LENGTH-1:0] x_i,
    input  logic [DATA_LENGTH-1:0] y_i,
    input  logic [DATA_LENGTH-1:0] m_i,
    input  logic [DATA_LENGTH-1:0] m_bl_i,
    input  logic [DIGIT_W-1:0]     m_prime_i,
    output logic                   busy_o,
    output logic [DATA_LENGTH-1:0] result_o,
    output logic                   valid_o,
    output logic                   error_o
);
    localparam int TW = DATA_LENGTH + DIGIT_W + 1;
    localparam int SW = DATA_LENGTH + DIGIT_W + 2;
    localparam int NW = $clog2(DATA_LENGTH + 1) + 1;
    localparam logic [DATA_LENGTH-1:0] DL_V = DATA_LENGTH'(DATA_LENGTH);

    typedef enum logic [1:0] {IDLE, ITER, REDUCE, DONE} state_t;
    state_t state, state_nxt;

    logic [DATA_LENGTH-1:0] x_q, y_q, m_q, result_q;
    logic [DIGIT_W-1:0]     mp_q;
    logic [NW-1:0]          n_q, cnt_q;
    logic [TW-1:0]          t_q;
    logic                   err_q;

    logic                   idle_like, accept, bad_ops, last_digit;
    logic [NW-1:0]          bl_eff, bl_sum, n_calc;
    logic [DIGIT_W-1:0]     xd, q_pre, q;
    logic [SW-1:0]          xy, qm, sum;
    logic [TW-1:0]          t_nxt, t_red;

`ifdef MONT_OPERAND_CHECK_EN
    assign bad_ops = ~m_i[0] | (x_i >= m_i) | (y_i >= m_i);
`else
    assign bad_ops = 1'b0;
`endif

    // Zero or oversized bit length falls back to the full operand width
    assign bl_eff = (m_bl_i == '0 || m_bl_i > DL_V) ? NW'(DATA_LENGTH) : m_bl_i[NW-1:0];
    assign bl_sum = bl_eff + NW'(DIGIT_W - 1);
    assign n_calc = bl_sum / NW'(DIGIT_W);

    assign idle_like  = (state == IDLE) || (state == DONE);
    assign accept     = start_i && idle_like;
    assign last_digit = (cnt_q == n_q - NW'(1));

    // One Montgomery digit step; q makes the low DIGIT_W bits of the sum vanish
    assign xd    = x_q[DIGIT_W-1:0];
    assign q_pre = t_q[DIGIT_W-1:0] + xd * y_q[DIGIT_W-1:0];
    assign q     = q_pre * mp_q;
    assign xy    = SW'(xd) * SW'(y_q);
    assign qm    = SW'(q) * SW'(m_q);
    assign sum   = SW'(t_q) + xy + qm;
    assign t_nxt = TW'(sum >> DIGIT_W);
    assign t_red = (t_q >= TW'(m_q)) ? t_q - TW'(m_q) : t_q;

    always_ff @(posedge CLK_pci_sys_clk_p or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = (accept && !bad_ops) ? ITER : IDLE;
            ITER:       if (last_digit) state_nxt = REDUCE;
            REDUCE:     state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_pci_sys_clk_p or posedge rst_i) begin
        if (rst_i) begin
            x_q      <= '0;
            y_q      <= '0;
            m_q      <= '0;
            mp_q     <= '0;
            n_q      <= '0;
            cnt_q    <= '0;
            t_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= accept && bad_ops;
            if (accept && !bad_ops) begin
                x_q   <= x_i;
                y_q   <= y_i;
                m_q   <= m_i;
                mp_q  <= m_prime_i;
                n_q   <= n_calc;
                cnt_q <= '0;
                t_q   <= '0;
            end else if (state == ITER) begin
                t_q   <= t_nxt;
                x_q   <= x_q >> DIGIT_W;
                cnt_q <= cnt_q + NW'(1);
            end else if (state == REDUCE) begin
                result_q <= DATA_LENGTH'(t_red);
            end
        end
    end

    assign busy_o   = (state == ITER) || (state == REDUCE);
    assign valid_o  = (state == DONE);
    assign result_o = result_q;
    assign error_o  = err_q;
endmodule
